// File: rtl/wbuart_pkg.sv
// Shared definitions for the UART transmit scheduler: register map, status
// and control bit positions, FSM state encoding and CR/address helpers.
package wbuart_pkg;

  // Register word indices relative to the UART base address
  localparam logic [1:0] UART_SR   = 2'd0;
  localparam logic [1:0] UART_CR   = 2'd1;
  localparam logic [1:0] UART_RXDR = 2'd2;
  localparam logic [1:0] UART_TXDR = 2'd3;

  // UART_SR bit positions
  localparam int SR_RXNE = 0;
  localparam int SR_TXE  = 1;
  localparam int SR_RXOE = 2;
  localparam int SR_FE   = 3;
  localparam int SR_PE   = 4;

  // UART_CR field positions
  localparam int CR_EN         = 0;
  localparam int CR_P_LSB      = 1;
  localparam int CR_S          = 3;
  localparam int CR_DS         = 4;
  localparam int CR_CLKDIV_LSB = 16;

  typedef enum logic [2:0] {
    ST_CFG_REQ,
    ST_CFG_ACK,
    ST_IDLE,
    ST_POLL_REQ,
    ST_POLL_ACK,
    ST_WR_REQ,
    ST_WR_ACK
  } state_e;

  // Byte address of a UART register given its word index
  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [1:0] idx);
    return base + {28'b0, idx, 2'b00};
  endfunction

  // Control word written once after reset; bit 0 enables the UART
  function automatic logic [31:0] cr_word(input logic [15:0] clk_div, input logic ds,
                                          input logic s, input logic [1:0] p);
    logic [31:0] w;
    w                      = '0;
    w[CR_CLKDIV_LSB +: 16] = clk_div;
    w[CR_DS]               = ds;
    w[CR_S]                = s;
    w[CR_P_LSB +: 2]       = p;
    w[CR_EN]               = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/wbuart_tx_scheduler_rr_arbiter.sv
// Round-robin priority search: grants the first requesting bit at or above
// ptr, wrapping past the top. Purely combinational.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_vld
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] cand;

  // Walk candidates starting at ptr; the first valid one wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!grant_vld && req[cand]) begin
        grant_vld   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/wbuart_tx_scheduler.sv
// Wishbone pipelined master: configures the UART once after reset, then
// serves byte requesters round-robin, polling TXE before each TXDR write.
module wbuart_tx_scheduler
  import wbuart_pkg::*;
#(
  parameter int          NUM_REQ   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [15:0] CLK_DIV   = 16'd868,
  parameter logic        CFG_DS    = 1'b0,
  parameter logic        CFG_S     = 1'b0,
  parameter logic [1:0]  CFG_P     = 2'b00
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 busy_o,
  output logic                 cfg_done_o,
  output logic [31:0]          wb_adr_o,
  output logic [31:0]          wb_dat_o,
  input  logic [31:0]          wb_dat_i,
  output logic                 wb_we_o,
  output logic [3:0]           wb_sel_o,
  output logic                 wb_stb_o,
  input  logic                 wb_ack_i,
  output logic                 wb_cyc_o,
  input  logic                 wb_stall_i
);

  localparam int          PTR_W   = $clog2(NUM_REQ);
  localparam logic [31:0] CR_DATA = cr_word(CLK_DIV, CFG_DS, CFG_S, CFG_P);

  state_e             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [7:0]         byte_q;
  logic [NUM_REQ-1:0] arb_grant;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_vld;
  logic [7:0]         byte_sel;
  logic               unused_dat;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid_i),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // Select the granted requester's byte with a one-hot OR mux
  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) byte_sel = byte_sel | req_data_i[8*i +: 8];
    end
  end

  // Accept pulse is only meaningful in the grant cycle
  assign req_ready_o = (state == ST_IDLE) ? arb_grant : '0;
  assign busy_o      = (state != ST_IDLE);
  assign wb_sel_o    = 4'hF;
  // Only TXE matters; reading SR clears the error flags, which is accepted
  assign unused_dat  = ^{wb_dat_i[31:SR_TXE+1], wb_dat_i[SR_TXE-1:0]};

  // Bus sequencer: each *_REQ state raises stb, holds it through stall,
  // then the matching *_ACK state waits for ack and drops cyc.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_CFG_REQ;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      cfg_done_o <= 1'b0;
      rr_ptr     <= '0;
      byte_q     <= '0;
    end else begin
      case (state)
        ST_CFG_REQ: begin
          if (!wb_stb_o) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_adr_o <= reg_addr(BASE_ADDR, UART_CR);
            wb_dat_o <= CR_DATA;
          end else if (!wb_stall_i) begin
            wb_stb_o <= 1'b0;
            state    <= ST_CFG_ACK;
          end
        end
        ST_CFG_ACK: begin
          if (wb_ack_i) begin
            wb_cyc_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            cfg_done_o <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (arb_vld) begin
            byte_q <= byte_sel;
            rr_ptr <= (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            state  <= ST_POLL_REQ;
          end
        end
        ST_POLL_REQ: begin
          if (!wb_stb_o) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b0;
            wb_adr_o <= reg_addr(BASE_ADDR, UART_SR);
            wb_dat_o <= '0;
          end else if (!wb_stall_i) begin
            wb_stb_o <= 1'b0;
            state    <= ST_POLL_ACK;
          end
        end
        ST_POLL_ACK: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            state    <= wb_dat_i[SR_TXE] ? ST_WR_REQ : ST_POLL_REQ;
          end
        end
        ST_WR_REQ: begin
          if (!wb_stb_o) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_adr_o <= reg_addr(BASE_ADDR, UART_TXDR);
            wb_dat_o <= {24'b0, byte_q};
          end else if (!wb_stall_i) begin
            wb_stb_o <= 1'b0;
            state    <= ST_WR_ACK;
          end
        end
        ST_WR_ACK: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_CFG_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_wbuart_tx_scheduler.sv
// Bench for wbuart_tx_scheduler: reactive Wishbone slave with random stall
// and ack latency, queue-backed requesters, and a transaction-level model.
module tb_wbuart_tx_scheduler;

  localparam int          N      = 4;
  localparam logic [31:0] CR_EXP = 32'h0364_0001;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } xact_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           busy, cfg_done;
  logic [31:0]    wb_adr, wb_dat_o, wb_dat_i;
  logic           wb_we, wb_stb, wb_ack, wb_cyc, wb_stall;
  logic [3:0]     wb_sel;

  always #5 clk = ~clk;

  wbuart_tx_scheduler #(.NUM_REQ(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .busy_o(busy), .cfg_done_o(cfg_done),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we),
    .wb_sel_o(wb_sel), .wb_stb_o(wb_stb), .wb_ack_i(wb_ack), .wb_cyc_o(wb_cyc),
    .wb_stall_i(wb_stall)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  rq_mem [N][16];
  int          rq_head [N];
  int          rq_tail [N];
  logic [31:0] sr_q[$];
  xact_t       log_q[$];
  xact_t       exp_q[$];
  int          grant_q[$];
  int          exp_grant_q[$];
  int          m_ptr;
  int          max_stall, min_ack, max_ack, wr_stall_fixed, wr_stall_seen;
  bit          pend;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit queues_empty();
    for (int n = 0; n < N; n++) if (rq_head[n] != rq_tail[n]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_byte(input int n, input logic [7:0] b);
    rq_mem[n][rq_tail[n]] = b;
    rq_tail[n]++;
  endtask

  task automatic clear_queues();
    for (int n = 0; n < N; n++) begin rq_head[n] = 0; rq_tail[n] = 0; end
  endtask

  // Reference: serve bytes in round-robin order from the model pointer; for
  // each byte script nr not-ready SR reads, one ready read, then the write.
  task automatic model_run(input int nr_min, input int nr_max, input bit rnd_bits);
    int h [N];
    int g;
    int nr;
    for (int n = 0; n < N; n++) h[n] = rq_head[n];
    forever begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && h[(m_ptr + k) % N] != rq_tail[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      if (g < 0) break;
      nr = $urandom_range(nr_max, nr_min);
      for (int r = 0; r < nr; r++) begin
        sr_q.push_back(rnd_bits ? ($urandom & 32'hFFFF_FFFD) : 32'h0);
        exp_q.push_back('{we: 1'b0, adr: 32'h0, dat: 32'h0});
      end
      sr_q.push_back(rnd_bits ? ($urandom | 32'h2) : 32'h2);
      exp_q.push_back('{we: 1'b0, adr: 32'h0, dat: 32'h0});
      exp_q.push_back('{we: 1'b1, adr: 32'hC, dat: {24'h0, rq_mem[g][h[g]]}});
      exp_grant_q.push_back(g);
      h[g]++;
      m_ptr = (g + 1) % N;
    end
  endtask

  task automatic compare_log(input string tag);
    check_eq({tag, "_nxact"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      check_eq({tag, "_we"}, 32'(log_q[i].we), 32'(exp_q[i].we));
      check_eq({tag, "_adr"}, log_q[i].adr, exp_q[i].adr);
      if (exp_q[i].we) check_eq({tag, "_dat"}, log_q[i].dat, exp_q[i].dat);
    end
    check_eq({tag, "_ngrant"}, 32'(grant_q.size()), 32'(exp_grant_q.size()));
    for (int i = 0; i < grant_q.size() && i < exp_grant_q.size(); i++)
      check_eq({tag, "_grant"}, 32'(grant_q[i]), 32'(exp_grant_q[i]));
    log_q.delete(); exp_q.delete(); grant_q.delete(); exp_grant_q.delete(); sr_q.delete();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int quiet = 0;
    int cyc   = 0;
    while (quiet < 3 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (!busy && !wb_cyc && !pend && queues_empty()) quiet++;
      else quiet = 0;
    end
    check_eq({tag, "_done"}, 32'(quiet >= 3), 32'd1);
  endtask

  // Slave, requester drivers and protocol monitor
  initial begin : bus_proc
    xact_t cur;
    int    stall_left, pend_dly;
    bit    in_req, issued_prev, repoll_due, ack_nr, pend_rd;
    wb_ack = 1'b0; wb_stall = 1'b0; wb_dat_i = '0;
    req_valid = '0; req_data = '0;
    stall_left = 0; pend_dly = 0; pend = 1'b0; pend_rd = 1'b0;
    in_req = 1'b0; issued_prev = 1'b0; repoll_due = 1'b0; ack_nr = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst && req_ready != '0) begin
        check_eq("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        check_eq("ready_only_idle", 32'(busy), 32'd0);
        for (int n = 0; n < N; n++) begin
          if (req_ready[n]) begin
            check_eq("ready_while_valid", 32'(req_valid[n]), 32'd1);
            grant_q.push_back(n);
            if (rq_head[n] != rq_tail[n]) rq_head[n]++;
          end
        end
      end
      @(posedge clk);
      #1;
      if (rst) begin
        pend = 1'b0; in_req = 1'b0; issued_prev = 1'b0; repoll_due = 1'b0;
        wb_ack = 1'b0; wb_stall = 1'b0;
      end else begin
        if (repoll_due) begin
          check_eq("repoll_after_gap", 32'(wb_stb && wb_cyc), 32'd1);
          repoll_due = 1'b0;
        end
        if (wb_ack) begin
          check_eq("cyc_after_ack", 32'(wb_cyc), 32'd0);
          repoll_due = ack_nr;
        end
        if (issued_prev) begin
          check_eq("stb_after_issue", 32'(wb_stb), 32'd0);
          check_eq("cyc_after_issue", 32'(wb_cyc), 32'd1);
          check_eq("sel", 32'(wb_sel), 32'hF);
        end
        issued_prev = 1'b0;
        wb_ack      = 1'b0;
        if (pend) begin
          if (pend_dly == 0) begin
            wb_ack = 1'b1;
            ack_nr = 1'b0;
            if (pend_rd) begin
              wb_dat_i = (sr_q.size() > 0) ? sr_q.pop_front() : 32'h2;
              ack_nr   = !wb_dat_i[1];
            end else begin
              wb_dat_i = $urandom;
            end
            pend = 1'b0;
          end else begin
            pend_dly--;
          end
        end
        if (wb_stb) begin
          if (!in_req) begin
            in_req     = 1'b1;
            cur        = '{we: wb_we, adr: wb_adr, dat: wb_dat_o};
            stall_left = (wb_we && wb_adr == 32'hC && wr_stall_fixed >= 0) ? wr_stall_fixed
                                                                            : $urandom_range(max_stall, 0);
          end else begin
            check_eq("stall_adr_stable", wb_adr, cur.adr);
            check_eq("stall_dat_stable", wb_dat_o, cur.dat);
            check_eq("stall_we_stable", 32'(wb_we), 32'(cur.we));
          end
          if (stall_left > 0) begin
            wb_stall = 1'b1;
            stall_left--;
            if (cur.we && cur.adr == 32'hC) wr_stall_seen++;
          end else begin
            wb_stall = 1'b0;
            log_q.push_back(cur);
            in_req      = 1'b0;
            issued_prev = 1'b1;
            pend        = 1'b1;
            pend_rd     = !cur.we;
            pend_dly    = $urandom_range(max_ack, min_ack);
          end
        end else begin
          wb_stall = 1'b0;
        end
      end
      for (int n = 0; n < N; n++) begin
        req_valid[n]       = (rq_head[n] != rq_tail[n]);
        req_data[8*n +: 8] = rq_mem[n][rq_head[n] % 16];
      end
    end
  end

  initial begin : main_proc
    int k;
    rst = 1'b1;
    max_stall = 0; min_ack = 0; max_ack = 0; wr_stall_fixed = -1; wr_stall_seen = 0;
    m_ptr = 0;
    clear_queues();
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_cyc", 32'(wb_cyc), 32'd0);
    check_eq("rst_stb", 32'(wb_stb), 32'd0);
    check_eq("rst_we", 32'(wb_we), 32'd0);
    check_eq("rst_adr", wb_adr, 32'd0);
    check_eq("rst_dat", wb_dat_o, 32'd0);
    check_eq("rst_sel", 32'(wb_sel), 32'hF);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_cfg_done", 32'(cfg_done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd1);

    // Configuration write after reset release
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{we: 1'b1, adr: 32'h4, dat: CR_EXP});
    wait_idle("cfg", 200);
    check_eq("cfg_done_set", 32'(cfg_done), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
    compare_log("cfg");

    // Single requester, UART ready at first poll
    clear_queues();
    push_byte(2, 8'h5A);
    model_run(0, 0, 1'b0);
    wait_idle("single", 300);
    compare_log("single");

    // Three not-ready polls before TXE
    clear_queues();
    push_byte(3, 8'hC3);
    model_run(3, 3, 1'b0);
    wait_idle("repoll", 300);
    compare_log("repoll");

    // All four requesters valid; requester 0 has a second byte
    clear_queues();
    push_byte(0, 8'h10); push_byte(0, 8'h10);
    push_byte(1, 8'h11); push_byte(2, 8'h12); push_byte(3, 8'h13);
    model_run(0, 0, 1'b0);
    wait_idle("fair", 500);
    compare_log("fair");

    // Long stall on the TXDR write
    clear_queues();
    wr_stall_fixed = 5; wr_stall_seen = 0;
    push_byte(1, 8'hA5);
    model_run(0, 0, 1'b0);
    wait_idle("wrstall", 300);
    check_eq("wrstall_cycles", 32'(wr_stall_seen), 32'd5);
    compare_log("wrstall");
    wr_stall_fixed = -1;

    // Randomized traffic, stalls, ack latency and SR contents
    max_stall = 2; max_ack = 3;
    for (int r = 0; r < 8; r++) begin
      clear_queues();
      for (int n = 0; n < N; n++) begin
        k = $urandom_range(3, 0);
        for (int b = 0; b < k; b++) push_byte(n, 8'($urandom));
      end
      model_run(0, 3, 1'b1);
      wait_idle("rand", 2000);
      compare_log("rand");
    end

    // Reset while waiting for the SR read ack
    max_stall = 0; min_ack = 6; max_ack = 6;
    clear_queues();
    push_byte(0, 8'h77);
    exp_q.push_back('{we: 1'b0, adr: 32'h0, dat: 32'h0});
    exp_grant_q.push_back(0);
    k = 0;
    while (log_q.size() == 0 && k < 100) begin
      @(posedge clk);
      #2;
      k++;
    end
    @(posedge clk);
    #3;
    check_eq("pre_rst_cyc", 32'(wb_cyc), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_cyc", 32'(wb_cyc), 32'd0);
    check_eq("async_rst_stb", 32'(wb_stb), 32'd0);
    compare_log("abort");
    repeat (2) @(negedge clk);
    check_eq("rst2_cfg_done", 32'(cfg_done), 32'd0);
    check_eq("rst2_busy", 32'(busy), 32'd1);
    check_eq("rst2_ready", 32'(req_ready), 32'd0);
    clear_queues();
    m_ptr = 0; min_ack = 0; max_ack = 2;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst2_cfg_pending", 32'(cfg_done), 32'd0);
    exp_q.push_back('{we: 1'b1, adr: 32'h4, dat: CR_EXP});
    wait_idle("recfg", 200);
    check_eq("recfg_done", 32'(cfg_done), 32'd1);
    compare_log("recfg");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
